// File: rtl/decode_stage_if.sv
// decode_stage port bundle: fetch handshake, register file
// read / write-back ports and the decoded result for execute.
interface decode_stage_if #(
  parameter int RF_AW = 5
);
  logic              enable;
  logic [31:0]       command;
  logic [31:0]       pc;
  logic              flush;
  logic              done;
  logic              stall;
  logic [RF_AW-1:0]  rf_raddr1;
  logic [RF_AW-1:0]  rf_raddr2;
  logic [31:0]       rf_rdata1;
  logic [31:0]       rf_rdata2;
  logic              wb_enable;
  logic [RF_AW-1:0]  wb_addr;
  logic [31:0]       wb_data;
  logic [31:0]       d_pc;
  logic [31:0]       d_op1;
  logic [31:0]       d_op2;
  logic [31:0]       d_imm;
  logic [RF_AW-1:0]  d_dst;
  logic [5:0]        d_opcode;
  logic [5:0]        d_funct;
  logic              d_reg_write;
  logic              d_is_load;
  logic              d_is_store;
  logic              d_is_branch;
  logic              d_is_jump;

  modport master (
    output enable, command, pc, flush,
    output rf_rdata1, rf_rdata2,
    output wb_enable, wb_addr, wb_data,
    input  done, stall,
    input  rf_raddr1, rf_raddr2,
    input  d_pc, d_op1, d_op2, d_imm,
    input  d_dst, d_opcode, d_funct,
    input  d_reg_write, d_is_load,
    input  d_is_store, d_is_branch, d_is_jump
  );

  modport slave (
    input  enable, command, pc, flush,
    input  rf_rdata1, rf_rdata2,
    input  wb_enable, wb_addr, wb_data,
    output done, stall,
    output rf_raddr1, rf_raddr2,
    output d_pc, d_op1, d_op2, d_imm,
    output d_dst, d_opcode, d_funct,
    output d_reg_write, d_is_load,
    output d_is_store, d_is_branch, d_is_jump
  );
endinterface

// File: rtl/decode_stage.sv
// MIPS-style decode stage with RAW scoreboard and wb bypass.
// Define DECODE_SCOREBOARD_EN for hazard tracking and stall.
module decode_stage #(
  parameter int RF_AW    = 5,
  parameter int LINK_REG = 31
) (
  input logic           clk,
  input logic           rstn,
  decode_stage_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    WAIT
  } state_t;

  typedef logic [RF_AW-1:0] reg_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] cmd_q;
  logic [31:0] pc_q;
  logic [5:0]  opc;
  reg_t        rs;
  reg_t        rt;
  reg_t        rd;
  reg_t        src1;
  reg_t        src2;
  reg_t        dst;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] jtgt;
  logic [31:0] imm;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        use1;
  logic        use2;
  logic        rw;
  logic        ld;
  logic        st;
  logic        br;
  logic        jp;
  logic        link;
  logic        hazard;
  logic        fire;

  assign opc  = cmd_q[31:26];
  assign rs   = cmd_q[21 +: RF_AW];
  assign rt   = cmd_q[16 +: RF_AW];
  assign rd   = cmd_q[11 +: RF_AW];
  assign sext = {{16{cmd_q[15]}}, cmd_q[15:0]};
  assign zext = {16'h0, cmd_q[15:0]};
  assign jtgt = {4'b0, cmd_q[25:0], 2'b00};

  // command 0 and unknown opcodes fall to default: a nop
  always_comb begin
    use1 = 1'b0;
    use2 = 1'b0;
    dst  = '0;
    imm  = '0;
    rw   = 1'b0;
    ld   = 1'b0;
    st   = 1'b0;
    br   = 1'b0;
    jp   = 1'b0;
    link = 1'b0;
    unique case (1'b1)
      opc == 6'b000000 && cmd_q != '0: begin
        use1 = 1'b1;
        use2 = 1'b1;
        dst  = rd;
        rw   = 1'b1;
      end
      opc[5:2] == 4'b0010: begin
        use1 = 1'b1;
        dst  = rt;
        rw   = 1'b1;
        imm  = sext;
      end
      opc == 6'b001100,
      opc == 6'b001101,
      opc == 6'b001110: begin
        use1 = 1'b1;
        dst  = rt;
        rw   = 1'b1;
        imm  = zext;
      end
      opc == 6'b001111: begin
        dst = rt;
        rw  = 1'b1;
        imm = {cmd_q[15:0], 16'h0};
      end
      opc == 6'b100011: begin
        use1 = 1'b1;
        dst  = rt;
        rw   = 1'b1;
        ld   = 1'b1;
        imm  = sext;
      end
      opc == 6'b101011: begin
        use1 = 1'b1;
        use2 = 1'b1;
        st   = 1'b1;
        imm  = sext;
      end
      opc[5:1] == 5'b00010: begin
        use1 = 1'b1;
        use2 = 1'b1;
        br   = 1'b1;
        imm  = {sext[29:0], 2'b00};
      end
      opc == 6'b000010: begin
        jp  = 1'b1;
        imm = jtgt;
      end
      opc == 6'b000011: begin
        jp   = 1'b1;
        link = 1'b1;
        rw   = 1'b1;
        dst  = reg_t'(LINK_REG);
        imm  = jtgt;
      end
      opc == 6'b110010: begin
        br  = 1'b1;
        imm = jtgt;
      end
      default: ;
    endcase
  end

  assign src1 = use1 ? rs : '0;
  assign src2 = use2 ? rt : '0;
  assign bus.rf_raddr1 = src1;
  assign bus.rf_raddr2 = src2;

  always_comb begin
    op1 = bus.rf_rdata1;
    if (bus.wb_enable && bus.wb_addr == src1)
      op1 = bus.wb_data;
    if (src1 == '0)
      op1 = '0;
    if (link)
      op1 = pc_q + 32'd4;
  end

  always_comb begin
    op2 = bus.rf_rdata2;
    if (bus.wb_enable && bus.wb_addr == src2)
      op2 = bus.wb_data;
    if (src2 == '0)
      op2 = '0;
  end

`ifdef DECODE_SCOREBOARD_EN
  localparam int NREG = 1 << RF_AW;

  logic [NREG-1:0] busy;
  logic            blk1;
  logic            blk2;

  // a write-back landing this cycle releases its register
  assign blk1 = src1 != '0 && busy[src1] &&
                !(bus.wb_enable && bus.wb_addr == src1);
  assign blk2 = src2 != '0 && busy[src2] &&
                !(bus.wb_enable && bus.wb_addr == src2);
  assign hazard    = blk1 | blk2;
  assign bus.stall = (state == WAIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy <= '0;
    end else begin
      if (bus.wb_enable)
        busy[bus.wb_addr] <= 1'b0;
      if (fire && rw && dst != '0)
        busy[dst] <= 1'b1;
    end
  end
`else
  assign hazard    = 1'b0;
  assign bus.stall = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    fire     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.enable)
          state_nx = CHECK;
      end
      CHECK, WAIT: begin
        if (bus.flush) begin
          state_nx = IDLE;
        end else if (hazard) begin
          state_nx = WAIT;
        end else begin
          state_nx = IDLE;
          fire     = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      cmd_q           <= '0;
      pc_q            <= '0;
      bus.done        <= 1'b0;
      bus.d_pc        <= '0;
      bus.d_op1       <= '0;
      bus.d_op2       <= '0;
      bus.d_imm       <= '0;
      bus.d_dst       <= '0;
      bus.d_opcode    <= '0;
      bus.d_funct     <= '0;
      bus.d_reg_write <= 1'b0;
      bus.d_is_load   <= 1'b0;
      bus.d_is_store  <= 1'b0;
      bus.d_is_branch <= 1'b0;
      bus.d_is_jump   <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.done <= fire;
      if (state == IDLE && bus.enable) begin
        cmd_q <= bus.command;
        pc_q  <= bus.pc;
      end
      if (fire) begin
        bus.d_pc        <= pc_q;
        bus.d_op1       <= op1;
        bus.d_op2       <= op2;
        bus.d_imm       <= imm;
        bus.d_dst       <= dst;
        bus.d_opcode    <= opc;
        bus.d_funct     <= cmd_q[5:0];
        bus.d_reg_write <= rw;
        bus.d_is_load   <= ld;
        bus.d_is_store  <= st;
        bus.d_is_branch <= br;
        bus.d_is_jump   <= jp;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Directed + random bench for decode_stage against a
// table-level decode model and a register-file array.
module tb_decode_stage;
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.RF_AW(5)) bus ();

  decode_stage #(
    .RF_AW(5),
    .LINK_REG(31)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct packed {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  dst;
    logic [31:0] imm;
    logic        rw;
    logic        ld;
    logic        st;
    logic        br;
    logic        jp;
    logic        link;
  } ref_t;

  logic [31:0] regs [32];
  bit          busy_m [32];
  int          errs = 0;
  int          checks = 0;

  assign bus.rf_rdata1 = regs[bus.rf_raddr1];
  assign bus.rf_rdata2 = regs[bus.rf_raddr2];

  function automatic ref_t ref_decode(logic [31:0] c);
    ref_t r = '0;
    logic [31:0] se = {{16{c[15]}}, c[15:0]};
    logic [31:0] tg = {4'b0, c[25:0], 2'b00};
    if (c == 32'd0) return r;
    case (c[31:26])
      6'd0: begin
        r.s1 = c[25:21]; r.s2 = c[20:16];
        r.dst = c[15:11]; r.rw = 1;
      end
      6'd8, 6'd9, 6'd10, 6'd11: begin
        r.s1 = c[25:21]; r.dst = c[20:16];
        r.rw = 1; r.imm = se;
      end
      6'd12, 6'd13, 6'd14: begin
        r.s1 = c[25:21]; r.dst = c[20:16];
        r.rw = 1; r.imm = 32'(c[15:0]);
      end
      6'd15: begin
        r.dst = c[20:16]; r.rw = 1;
        r.imm = 32'(c[15:0]) << 16;
      end
      6'd35: begin
        r.s1 = c[25:21]; r.dst = c[20:16];
        r.rw = 1; r.ld = 1; r.imm = se;
      end
      6'd43: begin
        r.s1 = c[25:21]; r.s2 = c[20:16];
        r.st = 1; r.imm = se;
      end
      6'd4, 6'd5: begin
        r.s1 = c[25:21]; r.s2 = c[20:16];
        r.br = 1; r.imm = se * 4;
      end
      6'd2: begin
        r.jp = 1; r.imm = tg;
      end
      6'd3: begin
        r.jp = 1; r.rw = 1; r.link = 1;
        r.dst = 5'd31; r.imm = tg;
      end
      6'd50: begin
        r.br = 1; r.imm = tg;
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] src_val(
    logic [4:0] s, bit wb_on,
    logic [4:0] wa, logic [31:0] wd);
    if (s == 5'd0) return 32'd0;
    if (wb_on && wa == s) return wd;
    return regs[s];
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag,
                           input logic [31:0] c,
                           input logic [31:0] p,
                           input logic [31:0] e1,
                           input logic [31:0] e2);
    ref_t r = ref_decode(c);
    chk({tag, ".pc"}, bus.d_pc, p);
    chk({tag, ".op1"}, bus.d_op1, e1);
    chk({tag, ".op2"}, bus.d_op2, e2);
    chk({tag, ".imm"}, bus.d_imm, r.imm);
    chk({tag, ".dst"}, 32'(bus.d_dst), 32'(r.dst));
    chk({tag, ".opc"}, 32'(bus.d_opcode), 32'(c[31:26]));
    chk({tag, ".fn"}, 32'(bus.d_funct), 32'(c[5:0]));
    chk({tag, ".flags"},
        32'({bus.d_reg_write, bus.d_is_load,
             bus.d_is_store, bus.d_is_branch,
             bus.d_is_jump}),
        32'({r.rw, r.ld, r.st, r.br, r.jp}));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".pc"}, bus.d_pc, 0);
    chk({tag, ".op1"}, bus.d_op1, 0);
    chk({tag, ".op2"}, bus.d_op2, 0);
    chk({tag, ".imm"}, bus.d_imm, 0);
    chk({tag, ".misc"},
        32'({bus.d_dst, bus.d_opcode, bus.d_funct,
             bus.d_reg_write, bus.d_is_load,
             bus.d_is_store, bus.d_is_branch,
             bus.d_is_jump}), 0);
    chk({tag, ".done"}, 32'(bus.done), 0);
    chk({tag, ".stall"}, 32'(bus.stall), 0);
  endtask

  task automatic wb(input logic [4:0] a,
                    input logic [31:0] d);
    bus.wb_enable = 1'b1;
    bus.wb_addr   = a;
    bus.wb_data   = d;
    @(negedge clk);
    bus.wb_enable = 1'b0;
    regs[a]   = d;
    busy_m[a] = 1'b0;
  endtask

  // one instruction with no hazard; optional wb in its CHECK cycle
  task automatic run(input string tag,
                     input logic [31:0] c,
                     input logic [31:0] p,
                     input bit wb_on,
                     input logic [4:0] wa,
                     input logic [31:0] wd);
    ref_t r = ref_decode(c);
    logic [31:0] e1;
    logic [31:0] e2;
    int lat;
    e1 = r.link ? p + 32'd4 : src_val(r.s1, wb_on, wa, wd);
    e2 = src_val(r.s2, wb_on, wa, wd);
    bus.enable  = 1'b1;
    bus.command = c;
    bus.pc      = p;
    @(negedge clk);
    bus.enable  = 1'b0;
    bus.command = $urandom;
    bus.pc      = $urandom;
    chk({tag, ".early"}, 32'(bus.done), 0);
    if (wb_on) begin
      bus.wb_enable = 1'b1;
      bus.wb_addr   = wa;
      bus.wb_data   = wd;
    end
    @(negedge clk);
    if (wb_on) begin
      bus.wb_enable = 1'b0;
      regs[wa]   = wd;
      busy_m[wa] = 1'b0;
    end
    lat = 2;
    while (!bus.done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, 2);
    check_out(tag, c, p, e1, e2);
    if (r.rw && r.dst != 5'd0) busy_m[r.dst] = 1'b1;
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(bus.done), 0);
  endtask

  logic [5:0]  ops [18];
  logic [31:0] c;
  ref_t        r;
  bit          wb_on;
  logic [4:0]  wa;

  initial begin
    ops = '{6'd0, 6'd8, 6'd9, 6'd10, 6'd11, 6'd12,
            6'd13, 6'd14, 6'd15, 6'd35, 6'd43, 6'd4,
            6'd5, 6'd2, 6'd3, 6'd50, 6'd63, 6'd28};
    regs[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < 32; i++) begin
      regs[i]   = $urandom;
      busy_m[i] = 1'b0;
    end
    busy_m[0]     = 1'b0;
    bus.enable    = 1'b0;
    bus.command   = '0;
    bus.pc        = '0;
    bus.flush     = 1'b0;
    bus.wb_enable = 1'b0;
    bus.wb_addr   = '0;
    bus.wb_data   = '0;

    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    run("addi", 32'h2001_0005, 32'h10, 0, 0, 0);

`ifdef DECODE_SCOREBOARD_EN
    bus.enable  = 1'b1;
    bus.command = 32'h2022_0001;
    bus.pc      = 32'h14;
    @(negedge clk);
    bus.enable  = 1'b0;
    @(negedge clk);
    chk("raw.stall", 32'(bus.stall), 1);
    chk("raw.nodone", 32'(bus.done), 0);
    bus.enable  = 1'b1;
    bus.command = 32'h3C1F_1234;
    bus.pc      = 32'h99;
    @(negedge clk);
    bus.enable  = 1'b0;
    chk("raw.hold", 32'(bus.stall), 1);
    chk("raw.nodone2", 32'(bus.done), 0);
    bus.wb_enable = 1'b1;
    bus.wb_addr   = 5'd1;
    bus.wb_data   = 32'd5;
    @(negedge clk);
    bus.wb_enable = 1'b0;
    chk("raw.done", 32'(bus.done), 1);
    chk("raw.release", 32'(bus.stall), 0);
    check_out("raw", 32'h2022_0001, 32'h14, 32'd5, 32'd0);
    regs[1]   = 32'd5;
    busy_m[1] = 1'b0;
    busy_m[2] = 1'b1;
    @(negedge clk);
    chk("raw.pulse", 32'(bus.done), 0);
`else
    run("raw", 32'h2022_0001, 32'h14, 0, 0, 0);
    wb(5'd1, 32'd5);
`endif

    run("ori", 32'h3403_FFFF, 32'h20, 0, 0, 0);
    run("beq", 32'h1000_FFFF, 32'h24, 0, 0, 0);
    run("jal", 32'h0C00_0010, 32'h40, 0, 0, 0);

    bus.enable  = 1'b1;
    bus.command = 32'h3409_0007;
    bus.pc      = 32'h44;
    @(negedge clk);
    bus.enable = 1'b0;
    bus.flush  = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush.nodone", 32'(bus.done), 0);
    chk("flush.stall", 32'(bus.stall), 0);
    @(negedge clk);
    chk("flush.nodone2", 32'(bus.done), 0);
    chk("flush.keep", bus.d_pc, 32'h40);
    run("after_flush", 32'h0120_5020, 32'h48, 0, 0, 0);

`ifdef DECODE_SCOREBOARD_EN
    bus.enable  = 1'b1;
    bus.command = 32'h0040_3020;
    bus.pc      = 32'h50;
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("wflush.stall", 32'(bus.stall), 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("wflush.low", 32'(bus.stall), 0);
    chk("wflush.nodone", 32'(bus.done), 0);
    @(negedge clk);
    chk("wflush.nodone2", 32'(bus.done), 0);
    chk("wflush.keep", bus.d_pc, 32'h48);
    bus.enable  = 1'b1;
    bus.command = 32'h0040_3020;
    bus.pc      = 32'h54;
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    chk("wflush.busy", 32'(bus.stall), 1);
    rstn = 1'b0;
    #1;
    chk_zero("rst_wait");
`else
    bus.enable  = 1'b1;
    bus.command = 32'h0040_3020;
    bus.pc      = 32'h54;
    @(negedge clk);
    bus.enable = 1'b0;
    rstn = 1'b0;
    #1;
    chk_zero("rst_check");
`endif
    for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
    @(negedge clk);
    chk("rst.nodone", 32'(bus.done), 0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst.after", 32'(bus.done), 0);

    run("post_rst", 32'h0040_3020, 32'h58, 0, 0, 0);
    run("lw", 32'h8C05_0008, 32'h60, 0, 0, 0);
    run("nop", 32'h0000_0000, 32'h64, 0, 0, 0);

    for (int i = 1; i < 32; i++)
      if (busy_m[i]) wb(5'(i), $urandom);

    for (int n = 0; n < 40; n++) begin
      c = {ops[$urandom_range(0, 17)], 26'($urandom)};
      if ($urandom_range(0, 9) == 0) c = 32'd0;
      r = ref_decode(c);
      wb_on = ($urandom_range(0, 1) != 0) &&
              (r.s1 != 5'd0 || r.s2 != 5'd0);
      wa = (r.s1 != 5'd0) ? r.s1 : r.s2;
      run($sformatf("rnd%0d", n), c,
          $urandom & 32'hFFFF_FFFC, wb_on, wa, $urandom);
      if (r.rw && r.dst != 5'd0) wb(r.dst, $urandom);
    end

    $display("Result: errors=%0d of %0d checks",
             errs, checks);
    $finish;
  end
endmodule
